// File: rtl/apb_pkg.sv
// Shared APB definitions for the master bridge and its address decoder.
package apb_pkg;
  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;
endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a CPU byte address onto a slave index inside the peripheral region.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int unsigned          NUM_SLAVES      = 4,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR       = 32'h1000_0000,
  parameter int unsigned          SLAVE_SPAN_LOG2 = 12
) (
  input  logic [APB_ADDR_W-1:0] addr,
  output logic [2:0]            sel_idx,
  output logic                  hit
);

  logic [APB_ADDR_W-1:0] offset;
  logic [APB_ADDR_W-1:0] slot;

  // Addresses below the base wrap to huge offsets, so the explicit compare guards them.
  always_comb begin
    offset  = addr - BASE_ADDR;
    slot    = offset >> SLAVE_SPAN_LOG2;
    hit     = (addr >= BASE_ADDR) && (slot < NUM_SLAVES);
    sel_idx = slot[2:0];
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-initiator APB master: CPU load/store requests to APB SETUP/ACCESS
// transfers, with slave decode, response mux and a wait-state timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned           NUM_SLAVES      = 4,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR       = 32'h1000_0000,
  parameter int unsigned           SLAVE_SPAN_LOG2 = 12,
  parameter int unsigned           TIMEOUT_CYCLES  = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             req,
  input  logic [APB_ADDR_W-1:0]            req_addr,
  input  logic [APB_DATA_W-1:0]            req_wdata,
  input  logic                             req_write,
  output logic                             rsp_ready,
  output logic [APB_DATA_W-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [APB_ADDR_W-1:0]            PADDR,
  output logic [APB_DATA_W-1:0]            PWDATA,
  output logic                             PWRITE,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  input  logic [NUM_SLAVES*APB_DATA_W-1:0] PRDATA_S,
  input  logic [NUM_SLAVES-1:0]            PREADY_S
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  apb_state_t            state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [2:0]            sel_idx;
  logic [2:0]            dec_idx;
  logic                  dec_hit;
  logic                  sel_ready;
  logic [APB_DATA_W-1:0] sel_rdata;

  apb_addr_decoder #(
    .NUM_SLAVES      (NUM_SLAVES),
    .BASE_ADDR       (BASE_ADDR),
    .SLAVE_SPAN_LOG2 (SLAVE_SPAN_LOG2)
  ) u_dec (
    .addr    (req_addr),
    .sel_idx (dec_idx),
    .hit     (dec_hit)
  );

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx == 3'(i)) begin
        sel_ready = PREADY_S[i];
        sel_rdata = PRDATA_S[APB_DATA_W*i +: APB_DATA_W];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      sel_idx   <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_ready <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_ready <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (dec_hit) begin
              PADDR   <= req_addr;
              PWDATA  <= req_wdata;
              PWRITE  <= req_write;
              PSEL    <= NUM_SLAVES'(1) << dec_idx;
              sel_idx <= dec_idx;
              state   <= SETUP;
            end else begin
              rsp_ready <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            rsp_ready <= 1'b1;
            if (!PWRITE) rsp_rdata <= sel_rdata;
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            wait_cnt <= '0;
            state    <= IDLE;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Counter value equals the number of prior unready ACCESS cycles.
            rsp_ready <= 1'b1;
            rsp_err   <= 1'b1;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            wait_cnt  <= '0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
